// File: rtl/multicycle_cpu_core.sv
// Multicycle MIPS-subset core: datapath and control FSM in one block, with a
// request/ready port to a unified memory and precise interrupt entry/return.
module multicycle_cpu_core #(
    parameter logic [31:0] RESET_PC   = 32'd128,
    parameter logic [31:0] IRQ_VECTOR = 32'd4088,
    parameter int          ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic              irq,
    output logic              irq_ack,
    output logic              in_isr,
    output logic [31:0]       pc,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_ERET   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_COP0  = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_SLT    = 6'b101010;
    localparam logic [5:0] F_ERET   = 6'b011000;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc, r_epc, r_ir, r_a, r_b, r_alu_out, r_mdr;
    logic        r_in_isr;
    logic        r_req_pend;
    logic [31:0] r_rf [32];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm_sext, w_jump_target, w_rs_val, w_rt_val;
    logic [31:0] w_alu_result, w_addr, w_rf_wdata;
    logic [4:0]  w_rf_waddr;
    logic        w_mem_req, w_mem_we, w_irq_take, w_rf_we;

    assign w_op          = r_ir[31:26];
    assign w_rs          = r_ir[25:21];
    assign w_rt          = r_ir[20:16];
    assign w_rd          = r_ir[15:11];
    assign w_funct       = r_ir[5:0];
    assign w_imm_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_jump_target = {r_pc[31:28], r_ir[25:0], 2'b00};
    assign w_rs_val      = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
    assign w_rt_val      = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

    // R-type ALU; unknown funct codes yield zero
    always_comb begin
        w_alu_result = 32'd0;
        case (w_funct)
            F_ADD:   w_alu_result = r_a + r_b;
            F_SUB:   w_alu_result = r_a - r_b;
            F_AND:   w_alu_result = r_a & r_b;
            F_OR:    w_alu_result = r_a | r_b;
            F_SLT:   w_alu_result = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
            default: w_alu_result = 32'd0;
        endcase
    end

    // Next-state, memory request and register-file write control
    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_addr       = r_pc;
        w_irq_take   = 1'b0;
        w_rf_we      = 1'b0;
        w_rf_waddr   = w_rt;
        w_rf_wdata   = r_alu_out;
        case (r_state)
            S_FETCH: begin
                // An interrupt may only replace a fetch that has not yet been issued
                if (irq && !r_in_isr && !r_req_pend) begin
                    w_irq_take = 1'b1;
                end else begin
                    w_mem_req = 1'b1;
                    if (mem_ready) w_next_state = S_DECODE;
                    else           w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                case (w_op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXEC;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    OP_JAL:       w_next_state = S_JAL;
                    OP_COP0: begin
                        if (w_funct == F_ERET) w_next_state = S_ERET;
                        else                   w_next_state = S_FETCH;
                    end
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (w_op == OP_SW) w_next_state = S_MEMWR;
                else               w_next_state = S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_addr    = r_alu_out;
                if (mem_ready) w_next_state = S_MEMWB;
                else           w_next_state = S_MEMRD;
            end
            S_MEMWB: begin
                w_rf_we      = 1'b1;
                w_rf_wdata   = r_mdr;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_addr    = r_alu_out;
                if (mem_ready) w_next_state = S_FETCH;
                else           w_next_state = S_MEMWR;
            end
            S_EXEC:   w_next_state = S_ALUWB;
            S_ALUWB: begin
                w_rf_we      = 1'b1;
                w_rf_waddr   = w_rd;
                w_next_state = S_FETCH;
            end
            S_ADDIEX: w_next_state = S_ADDIWB;
            S_ADDIWB: begin
                w_rf_we      = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                w_rf_we      = 1'b1;
                w_rf_waddr   = 5'd31;
                w_rf_wdata   = r_pc;
                w_next_state = S_FETCH;
            end
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Handshake outputs are forced low for as long as reset is held
    always_comb begin
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            irq_ack = 1'b0;
        end else begin
            mem_req = w_mem_req;
            mem_we  = w_mem_we;
            irq_ack = w_irq_take;
        end
    end

    assign mem_addr  = w_addr[ADDR_W-1:0];
    assign mem_wdata = r_b;
    assign pc        = r_pc;
    assign in_isr    = r_in_isr;
    assign state     = r_state;

    // Architectural and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_epc      <= 32'd0;
            r_ir       <= 32'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_alu_out  <= 32'd0;
            r_mdr      <= 32'd0;
            r_in_isr   <= 1'b0;
            r_req_pend <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_req_pend <= w_mem_req & ~mem_ready;
            case (r_state)
                S_FETCH: begin
                    if (w_irq_take) begin
                        r_epc    <= r_pc;
                        r_pc     <= IRQ_VECTOR;
                        r_in_isr <= 1'b1;
                    end else if (mem_ready) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    r_a       <= w_rs_val;
                    r_b       <= w_rt_val;
                    r_alu_out <= r_pc + (w_imm_sext << 2);
                end
                S_MEMADR, S_ADDIEX: r_alu_out <= r_a + w_imm_sext;
                S_MEMRD: begin
                    if (mem_ready) r_mdr <= mem_rdata;
                end
                S_EXEC:   r_alu_out <= w_alu_result;
                S_BRANCH: begin
                    if (r_a == r_b) r_pc <= r_alu_out;
                end
                S_JUMP, S_JAL: r_pc <= w_jump_target;
                S_ERET: begin
                    r_pc     <= r_epc;
                    r_in_isr <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Register file keeps its contents across reset; r0 is never written
    always_ff @(posedge clk) begin
        if (w_rf_we && (w_rf_waddr != 5'd0)) r_rf[w_rf_waddr] <= w_rf_wdata;
    end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Bench for multicycle_cpu_core: an instruction-level reference model with a
// per-instruction cycle schedule, driven by directed and random programs.
module tb_multicycle_cpu_core;

    localparam logic [31:0] RST_PC  = 32'd128;
    localparam logic [31:0] IRQ_VEC = 32'd4088;
    localparam int M_BOUND = 0;
    localparam int M_FWAIT = 1;
    localparam int M_RUN   = 2;

    typedef struct packed {
        logic        acc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } step_t;

    logic        clk = 1'b0;
    logic        reset, mem_req, mem_we, mem_ready, irq, irq_ack, in_isr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [3:0]  state, fetch_code;

    logic [31:0] tb_mem [1024];
    logic [31:0] m_mem  [1024];
    logic [31:0] m_rf   [32];
    logic [31:0] m_pc, m_epc, f_pc;
    logic        m_isr;
    int          mode;
    step_t       q[$];
    int          n_checks, n_errors;

    multicycle_cpu_core dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .irq(irq), .irq_ack(irq_ack), .in_isr(in_isr),
        .pc(pc), .state(state)
    );

    always #5 clk = ~clk;
    assign mem_rdata = tb_mem[mem_addr[11:2]];

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'd0, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    function automatic logic [4:0] rr();
        int v;
        v = $urandom_range(0, 8);
        return (v == 8) ? 5'd31 : 5'(v);
    endfunction

    function automatic logic [31:0] rand_instr();
        int         k;
        logic [5:0] f;
        k = $urandom_range(0, 15);
        case (k)
            0, 1:  return enc_i(6'h23, rr(), rr(), 16'($urandom_range(0, 255)) << 2);
            2, 3:  return enc_i(6'h2B, rr(), rr(), 16'($urandom_range(0, 255)) << 2);
            4, 5, 6: begin
                case ($urandom_range(0, 5))
                    0:       f = 6'h20;
                    1:       f = 6'h22;
                    2:       f = 6'h24;
                    3:       f = 6'h25;
                    4:       f = 6'h2A;
                    default: f = 6'($urandom);
                endcase
                return enc_r(rr(), rr(), rr(), f);
            end
            9:     return enc_i(6'h04, rr(), rr(), 16'($urandom_range(0, 15) - 8));
            10:    return enc_j(6'h02, 26'($urandom));
            11:    return enc_j(6'h03, 26'($urandom));
            12:    return 32'h4200_0018;
            13:    return {6'($urandom), 26'($urandom)};
            default: return enc_i(6'h08, rr(), rr(), 16'($urandom));
        endcase
    endfunction

    task automatic put(input int idx, input logic [31:0] w);
        tb_mem[idx] = w;
        m_mem[idx]  = w;
    endtask

    task automatic load_directed();
        for (int i = 0; i < 1024; i++) put(i, 32'd0);
        put(32, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(33, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        put(34, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        put(35, enc_r(5'd2, 5'd1, 5'd4, 6'h2A));
        put(36, enc_r(5'd2, 5'd1, 5'd5, 6'h22));
        put(37, enc_i(6'h08, 5'd0, 5'd0, 16'd7));
        put(38, enc_i(6'h2B, 5'd0, 5'd3, 16'd16));
        put(39, enc_i(6'h2B, 5'd0, 5'd4, 16'd20));
        put(40, enc_i(6'h2B, 5'd0, 5'd5, 16'd24));
        put(41, enc_i(6'h2B, 5'd0, 5'd0, 16'd28));
        put(42, enc_i(6'h23, 5'd0, 5'd6, 16'd16));
        put(43, enc_i(6'h2B, 5'd0, 5'd6, 16'd32));
        put(44, enc_i(6'h04, 5'd1, 5'd1, 16'd2));
        put(45, enc_i(6'h2B, 5'd0, 5'd1, 16'd36));
        put(46, enc_i(6'h2B, 5'd0, 5'd1, 16'd36));
        put(47, enc_i(6'h04, 5'd1, 5'd2, 16'd5));
        put(48, enc_j(6'h03, 26'd80));
        put(80, enc_i(6'h2B, 5'd0, 5'd31, 16'd40));
        put(81, enc_j(6'h02, 26'd81));
    endtask

    task automatic load_random();
        for (int i = 0; i < 1024; i++) put(i, rand_instr());
        for (int i = 0; i < 8; i++)
            put(32 + i, enc_i(6'h08, 5'd0, (i == 7) ? 5'd31 : 5'(i + 1), 16'($urandom)));
        put(1022, enc_i(6'h08, 5'd7, 5'd7, 16'd1));
        put(1023, 32'h4200_0018);
    endtask

    task automatic model_init();
        m_pc  = RST_PC;
        m_epc = 32'd0;
        m_isr = 1'b0;
        mode  = M_BOUND;
        q.delete();
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back('{acc: 1'b0, we: 1'b0, addr: 32'd0, wdata: 32'd0});
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_rf[r] = v;
    endtask

    // Architectural effect of one instruction plus its post-fetch cycle schedule
    task automatic execute();
        logic [31:0] ir, a, b, se, ea, res, tgt;
        logic [4:0]  rs, rt, rd;
        ir   = m_mem[f_pc[11:2]];
        m_pc = f_pc + 32'd4;
        rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
        a  = (rs == 5'd0) ? 32'd0 : m_rf[rs];
        b  = (rt == 5'd0) ? 32'd0 : m_rf[rt];
        se = {{16{ir[15]}}, ir[15:0]};
        ea = a + se;
        tgt = {m_pc[31:28], ir[25:0], 2'b00};
        case (ir[31:26])
            6'h23: begin
                push_idle(2);
                q.push_back('{acc: 1'b1, we: 1'b0, addr: ea, wdata: 32'd0});
                push_idle(1);
                wr(rt, m_mem[ea[11:2]]);
            end
            6'h2B: begin
                push_idle(2);
                q.push_back('{acc: 1'b1, we: 1'b1, addr: ea, wdata: b});
                m_mem[ea[11:2]] = b;
            end
            6'h00: begin
                case (ir[5:0])
                    6'h20:   res = a + b;
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: res = 32'd0;
                endcase
                push_idle(3);
                wr(rd, res);
            end
            6'h04: begin
                if (a == b) m_pc = m_pc + (se << 2);
                push_idle(2);
            end
            6'h08: begin
                wr(rt, ea);
                push_idle(3);
            end
            6'h02: begin
                m_pc = tgt;
                push_idle(2);
            end
            6'h03: begin
                wr(5'd31, m_pc);
                m_pc = tgt;
                push_idle(2);
            end
            6'h10: begin
                if (ir[5:0] == 6'h18) begin
                    m_pc  = m_epc;
                    m_isr = 1'b0;
                    push_idle(2);
                end else begin
                    push_idle(1);
                end
            end
            default: push_idle(1);
        endcase
        mode = M_RUN;
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance the model
    task automatic check_cycle();
        step_t s;
        case (mode)
            M_BOUND: begin
                chk32("pc", pc, m_pc);
                chk1("in_isr", in_isr, m_isr);
                chk1("state_fetch", state == fetch_code, 1'b1);
                if (irq && !m_isr) begin
                    chk1("irq_ack", irq_ack, 1'b1);
                    chk1("req_irq", mem_req, 1'b0);
                    m_epc = m_pc;
                    m_pc  = IRQ_VEC;
                    m_isr = 1'b1;
                end else begin
                    chk1("irq_ack", irq_ack, 1'b0);
                    chk1("fetch_req", mem_req, 1'b1);
                    chk1("fetch_we", mem_we, 1'b0);
                    chk32("fetch_addr", mem_addr, m_pc);
                    f_pc = m_pc;
                    if (mem_ready) execute();
                    else           mode = M_FWAIT;
                end
            end
            M_FWAIT: begin
                chk1("irq_ack", irq_ack, 1'b0);
                chk1("fetch_req", mem_req, 1'b1);
                chk1("fetch_we", mem_we, 1'b0);
                chk32("fetch_addr", mem_addr, f_pc);
                if (mem_ready) execute();
            end
            default: begin
                s = q[0];
                chk1("irq_ack", irq_ack, 1'b0);
                chk1("state_busy", state != fetch_code, 1'b1);
                chk1("req", mem_req, s.acc);
                if (s.acc) begin
                    chk1("we", mem_we, s.we);
                    chk32("data_addr", mem_addr, s.addr);
                    if (s.we) chk32("wdata", mem_wdata, s.wdata);
                end
                if (!s.acc || mem_ready) void'(q.pop_front());
                if (q.size() == 0) mode = M_BOUND;
            end
        endcase
    endtask

    task automatic run_cycles(input int n, input bit use_irq, input int hold);
        for (int c = 0; c < n; c++) begin
            if (!use_irq || c < hold)           irq = 1'b0;
            else if ($urandom_range(0, 15) == 0) irq = ~irq;
            mem_ready = ($urandom_range(0, 2) != 0);
            #1;
            check_cycle();
            if (mem_req && mem_we && mem_ready) tb_mem[mem_addr[11:2]] = mem_wdata;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        irq       = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        load_directed();
        repeat (3) @(negedge clk);
        #1;
        chk32("rst_pc", pc, 32'd128);
        chk1("rst_in_isr", in_isr, 1'b0);
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk1("rst_ack", irq_ack, 1'b0);
        fetch_code = state;
        @(negedge clk);
        reset = 1'b0;
        model_init();
        #1;
        chk1("first_req", mem_req, 1'b1);
        chk32("first_addr", mem_addr, 32'd128);
        run_cycles(400, 1'b0, 0);
        chk32("sum_r3", tb_mem[4], 32'd2);
        chk32("slt_r4", tb_mem[5], 32'd1);
        chk32("sub_r5", tb_mem[6], 32'hFFFF_FFF8);
        chk32("r0_zero", tb_mem[7], 32'd0);
        chk32("lw_r6", tb_mem[8], 32'd2);
        chk32("beq_skip", tb_mem[9], 32'd0);
        chk32("jal_r31", tb_mem[10], 32'd196);
        chk32("loop_pc", m_pc, 32'd324);
        for (int r = 0; r < 4; r++) begin
            reset = 1'b1;
            #1;
            chk1("midrst_req", mem_req, 1'b0);
            chk1("midrst_we", mem_we, 1'b0);
            chk1("midrst_ack", irq_ack, 1'b0);
            chk32("midrst_pc", pc, RST_PC);
            load_random();
            repeat (2) @(negedge clk);
            model_init();
            reset = 1'b0;
            run_cycles(3000, 1'b1, 150);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu_core.md
Name: multicycle_cpu_core

Overview:
- Self-contained multicycle MIPS-subset core: the register-transfer datapath plus its own control FSM in a single block.
- Talks to one unified instruction/data memory through a request/ready handshake, so the memory may insert wait states.
- Adds precise interrupt entry and return (EPC, eret), a hardwired-zero r0, and parametrised reset and vector addresses.
- Sits between the top-level memory model and the interrupt source; replaces the separate datapath/controller pair.

Parameters:
- RESET_PC, 32'd128, PC value loaded on reset.
- IRQ_VECTOR, 32'd4088, PC loaded on interrupt entry.
- ADDR_W, 32, width of mem_addr; the low ADDR_W bits of the internal 32-bit address are driven.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory access request; held until mem_ready.
- mem_we  out  1  write enable, valid while mem_req is high.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  32  store data (register B).
- mem_rdata  in  32  read data, valid in the cycle mem_ready is high.
- mem_ready  in  1  access completes on the clk edge where mem_req and mem_ready are both high.
- irq  in  1  level interrupt request.
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- in_isr  out  1  high from interrupt entry until eret.
- pc  out  32  current PC (debug).
- state  out  4  FSM state encoding (debug).

Behaviour:
- Reset (asynchronous):
  - PC=RESET_PC, EPC=0, IR=0, in_isr=0, state=FETCH.
  - mem_req, mem_we and irq_ack are 0 while reset is asserted.
  - Register file is not cleared, except r0 reads 0 always.
- FETCH:
  - If irq=1 and in_isr=0, the interrupt is taken instead of the fetch, in one cycle: EPC<=PC, PC<=IRQ_VECTOR, in_isr<=1, irq_ack=1; stay in FETCH.
  - Otherwise mem_req=1, mem_addr=PC. On ready: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - Latch A<=rf[rs], B<=rf[rt], ALUOut<=PC+(signext(imm)<<2).
  - Branch on op:
    - 100011/101011 -> MEMADR.
    - 000000 -> EXEC.
    - 000100 -> BRANCH.
    - 001000 -> ADDIEX.
    - 000010 -> JUMP.
    - 000011 -> JAL.
    - op=010000 with funct=011000 -> ERET.
    - All other opcodes: no architectural effect, back to FETCH.
- MEMADR: ALUOut<=A+signext(imm); go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, mem_we=0, addr=ALUOut. On ready, MDR<=mem_rdata, go to MEMWB.
- MEMWB: rf[rt]<=MDR; go to FETCH.
- MEMWR: mem_req=1, mem_we=1, wdata=B. On ready, go to FETCH.
- EXEC:
  - funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed; result 1 or 0).
  - Other funct codes give result 0.
  - ALUOut<=result; go to ALUWB.
- ALUWB: rf[rd]<=ALUOut; go to FETCH.
- BRANCH: if A==B, PC<=ALUOut; go to FETCH.
- ADDIEX: ALUOut<=A+signext(imm); go to ADDIWB, where rf[rt]<=ALUOut; go to FETCH.
- JUMP: PC<={PC[31:28], IR[25:0], 2'b00}; go to FETCH.
- JAL: rf[31]<=PC (already PC+4) and PC<=jump target, in the same cycle; go to FETCH.
- ERET: PC<=EPC, in_isr<=0; go to FETCH.
  - irq still high then re-enters at the next FETCH.
- Arithmetic: all adds wrap modulo 2^32; there is no overflow trap.
- Writes to r0 are discarded.
- Wait states: while mem_req=1 and mem_ready=0, the FSM, address and write data hold steady. Nested interrupts are not accepted while in_isr=1.
- Latency with mem_ready tied high:
  - 3 cycles: beq, j, jal, eret.
  - 4 cycles: R-type, sw, addi.
  - 5 cycles: lw.
  - Each wait cycle adds 1.
- Reset asserted mid-access: mem_req drops immediately; any pending store is not performed.

Test Plan:
- Reset release, ready tied high -> first mem_req at addr 128; after 4 fetched instructions of differing types, pc follows 128,132,136,140.
- addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1; sub r5,r2,r1 -> r3=2, r4=1, r5=0xFFFFFFF8; addi r0,r0,7 leaves r0=0.
- sw r3,16(r0) then lw r6,16(r0), with mem_ready low 2 cycles per access -> write at addr 16 with data 2 and mem_we held 3 cycles; r6=2; lw takes 7 cycles total.
- beq r1,r1,+2 at PC 200 -> next fetch 212; beq r1,r2 not taken -> next fetch 204; j 0x40 -> fetch at 0x100.
- jal at PC 300 -> r31=304, PC = jump target, 3 cycles.
- irq raised while lw is in MEMRD -> lw completes; at the next FETCH, irq_ack pulses once, EPC = next PC, fetch from 4088. irq held high inside the ISR gives no second ack. eret -> resume at EPC, in_isr=0.
